// File: rtl/ps2_zx_matrix.sv
// ps2_zx_matrix: PS/2 set-2 scancode stream to ZX Spectrum 8x5 keyboard matrix,
// with a combinational port 0xFE half-row read path.
module ps2_zx_matrix #(
    parameter int TIMEOUT_CYC = 1000000,
    parameter int CNT_W       = 20
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  ps2data,
    input  logic        ps2hit,
    input  logic [15:0] A,
    output logic [7:0]  D
);
    typedef enum logic [2:0] {IDLE, EXT, BRK, EXTBRK, PAUSE} state_t;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    state_t            state, state_nx;
    logic [2:0]        skip, skip_nx;
    logic [CNT_W-1:0]  cnt;
    logic [39:0]       key, comp, eff;
    logic [4:0]        flag, col;
    logic              make, brk, clr, ext_sel;
    logic              dk_hit, df_hit;
    logic [5:0]        dk_idx;
    logic [2:0]        df_idx;
    logic [7:0]        a_lo_unused;
    assign a_lo_unused = A[7:0];
    assign ext_sel = (state == EXT) || (state == EXTBRK);
    // Key index is row*5+col; flags are bksp, left, down, up, right.
    always_comb begin
        dk_hit = 1'b1;
        dk_idx = 6'd0;
        df_hit = 1'b0;
        df_idx = 3'd0;
        case ({ext_sel, ps2data})
            9'h012, 9'h059: dk_idx = 6'd0;
            9'h01A: dk_idx = 6'd1;
            9'h022: dk_idx = 6'd2;
            9'h021: dk_idx = 6'd3;
            9'h02A: dk_idx = 6'd4;
            9'h01C: dk_idx = 6'd5;
            9'h01B: dk_idx = 6'd6;
            9'h023: dk_idx = 6'd7;
            9'h02B: dk_idx = 6'd8;
            9'h034: dk_idx = 6'd9;
            9'h015: dk_idx = 6'd10;
            9'h01D: dk_idx = 6'd11;
            9'h024: dk_idx = 6'd12;
            9'h02D: dk_idx = 6'd13;
            9'h02C: dk_idx = 6'd14;
            9'h016: dk_idx = 6'd15;
            9'h01E: dk_idx = 6'd16;
            9'h026: dk_idx = 6'd17;
            9'h025: dk_idx = 6'd18;
            9'h02E: dk_idx = 6'd19;
            9'h045: dk_idx = 6'd20;
            9'h046: dk_idx = 6'd21;
            9'h03E: dk_idx = 6'd22;
            9'h03D: dk_idx = 6'd23;
            9'h036: dk_idx = 6'd24;
            9'h04D: dk_idx = 6'd25;
            9'h044: dk_idx = 6'd26;
            9'h043: dk_idx = 6'd27;
            9'h03C: dk_idx = 6'd28;
            9'h035: dk_idx = 6'd29;
            9'h05A: dk_idx = 6'd30;
            9'h04B: dk_idx = 6'd31;
            9'h042: dk_idx = 6'd32;
            9'h03B: dk_idx = 6'd33;
            9'h033: dk_idx = 6'd34;
            9'h029: dk_idx = 6'd35;
            9'h014, 9'h114: dk_idx = 6'd36;
            9'h03A: dk_idx = 6'd37;
            9'h031: dk_idx = 6'd38;
            9'h032: dk_idx = 6'd39;
            9'h066: begin dk_hit = 1'b0; df_hit = 1'b1; df_idx = 3'd0; end
            9'h16B: begin dk_hit = 1'b0; df_hit = 1'b1; df_idx = 3'd1; end
            9'h172: begin dk_hit = 1'b0; df_hit = 1'b1; df_idx = 3'd2; end
            9'h175: begin dk_hit = 1'b0; df_hit = 1'b1; df_idx = 3'd3; end
            9'h174: begin dk_hit = 1'b0; df_hit = 1'b1; df_idx = 3'd4; end
            default: dk_hit = 1'b0;
        endcase
    end
    always_comb begin
        state_nx = state;
        skip_nx  = skip;
        make     = 1'b0;
        brk      = 1'b0;
        clr      = 1'b0;
        if (ps2hit) begin
            case (state)
                IDLE: begin
                    if (ps2data == 8'hE0) state_nx = EXT;
                    else if (ps2data == 8'hF0) state_nx = BRK;
                    else if (ps2data == 8'hE1) begin
                        state_nx = PAUSE;
                        skip_nx  = 3'd7;
                    end else if (ps2data == 8'hAA || ps2data == 8'hFF || ps2data == 8'h00) clr = 1'b1;
                    else make = 1'b1;
                end
                EXT: begin
                    if (ps2data == 8'hF0) state_nx = EXTBRK;
                    else if (ps2data != 8'hE0) begin
                        make     = 1'b1;
                        state_nx = IDLE;
                    end
                end
                BRK, EXTBRK: begin
                    brk      = 1'b1;
                    state_nx = IDLE;
                end
                PAUSE: begin
                    skip_nx  = skip - 3'd1;
                    state_nx = (skip == 3'd1) ? IDLE : PAUSE;
                end
                default: state_nx = IDLE;
            endcase
        end else if (state != IDLE && cnt == CNT_LAST) state_nx = IDLE;
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            skip  <= 3'd0;
            cnt   <= '0;
            key   <= '0;
            flag  <= '0;
        end else begin
            state <= state_nx;
            skip  <= skip_nx;
            cnt   <= ps2hit ? '0 : (state != IDLE) ? cnt + CNT_ONE : cnt;
            if (clr) begin
                key  <= '0;
                flag <= '0;
            end else if (make || brk) begin
                if (dk_hit) key[dk_idx] <= make;
                if (df_hit) flag[df_idx] <= make;
            end
        end
    end
    // Composite keys OR in CS plus their digit, so held Shift survives their release.
    always_comb begin
        comp     = '0;
        comp[0]  = |flag;
        comp[20] = flag[0];
        comp[19] = flag[1];
        comp[24] = flag[2];
        comp[23] = flag[3];
        comp[22] = flag[4];
    end
    assign eff = key | comp;
    always_comb begin
        col = 5'b0;
        for (int r = 0; r < 8; r++)
            if (!A[8+r]) col = col | eff[r*5 +: 5];
        D = {3'b111, ~col};
    end
endmodule
